// File: rtl/peripheral_dbg_soc_dii_channel_pkg.sv
// Shared debug-interconnect flit type plus the byte-beat encoding used on
// inter-subnet links.
package peripheral_dbg_soc_dii_channel;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    localparam logic BEAT_LO = 1'b0;
    localparam logic BEAT_HI = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LO   = 2'd1,
        TX_HI   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/peripheral_dbg_soc_ring_router_ext_fifo.sv
// Show-ahead flit FIFO for the link receive side; a pop in the same cycle as
// a push while full frees the slot first, so both proceed.
module peripheral_dbg_soc_ring_router_ext_fifo
    import peripheral_dbg_soc_dii_channel::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [16:0] push_flit,
    input  logic        pop,
    output dii_flit     head,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_flit;
    end

    always_comb begin
        head.valid = !empty;
        head.last  = mem[rd_ptr][16];
        head.data  = mem[rd_ptr][15:0];
    end

endmodule

// File: rtl/peripheral_dbg_soc_ring_router_ext_link.sv
// Inter-subnet link endpoint: serializes gateway flits into credit-controlled
// byte beats and reassembles, filters and buffers flits from the peer.
module peripheral_dbg_soc_ring_router_ext_link
    import peripheral_dbg_soc_dii_channel::*;
#(
    parameter int CREDITS      = 4,
    parameter int SUBNET_BITS  = 6,
    parameter int LOCAL_SUBNET = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  dii_flit    dii_in,
    output logic       dii_in_ready,
    output dii_flit    dii_out,
    input  logic       dii_out_ready,
    output logic [7:0] link_tx_data,
    output logic       link_tx_valid,
    output logic       link_tx_hi,
    output logic       link_tx_last,
    input  logic [1:0] link_credit_in,
    input  logic [7:0] link_rx_data,
    input  logic       link_rx_valid,
    input  logic       link_rx_hi,
    input  logic       link_rx_last,
    output logic [1:0] link_credit_out,
    output logic [7:0] drop_count
);

    localparam int CW = $clog2(CREDITS + 1);

    tx_state_e     state;
    tx_state_e     state_next;
    logic [CW-1:0] credits;
    logic [CW:0]   credit_sum;
    logic          tx_hs;
    logic [15:0]   hold_data;
    logic          hold_last;

    assign dii_in_ready = (credits != '0) && (state == TX_IDLE || state == TX_HI);
    assign tx_hs        = dii_in.valid && dii_in_ready;
    assign credit_sum   = {1'b0, credits} + (CW+1)'(link_credit_in) - (CW+1)'(tx_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            credits <= CW'(CREDITS);
        end else begin
            assert (credit_sum <= (CW+1)'(CREDITS));
            state   <= state_next;
            credits <= (credit_sum > (CW+1)'(CREDITS)) ? CW'(CREDITS) : credit_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (tx_hs) begin
            hold_data <= dii_in.data;
            hold_last <= dii_in.last;
        end
    end

    // Beats come only from state and holding register, never from dii_in.
    always_comb begin
        state_next    = state;
        link_tx_valid = 1'b0;
        link_tx_hi    = BEAT_LO;
        link_tx_last  = 1'b0;
        link_tx_data  = '0;
        unique case (state)
            TX_IDLE: if (tx_hs) state_next = TX_LO;
            TX_LO: begin
                link_tx_valid = 1'b1;
                link_tx_data  = hold_data[7:0];
                state_next    = TX_HI;
            end
            TX_HI: begin
                link_tx_valid = 1'b1;
                link_tx_hi    = BEAT_HI;
                link_tx_last  = hold_last;
                link_tx_data  = hold_data[15:8];
                state_next    = tx_hs ? TX_LO : TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    logic        have_lo;
    logic [7:0]  lo_byte;
    logic        in_pkt;
    logic        dropping;
    logic        asm_vld;
    logic [15:0] asm_data;
    logic        foreign;
    logic        drop_flit;
    logic        keep;
    logic        pop;
    logic        overflow;
    logic        fifo_full;
    logic        fifo_empty;

    assign asm_vld   = link_rx_valid && (link_rx_hi == BEAT_HI) && have_lo;
    assign asm_data  = {link_rx_data, lo_byte};
    assign foreign   = asm_data[15 -: SUBNET_BITS] != SUBNET_BITS'(LOCAL_SUBNET);
    assign drop_flit = asm_vld && (in_pkt ? dropping : foreign);
    assign keep      = asm_vld && !drop_flit;
    assign pop       = !fifo_empty && dii_out_ready;
    // A full FIFO is only writable when the same-cycle pop frees a slot.
    assign overflow  = keep && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_lo         <= 1'b0;
            in_pkt          <= 1'b0;
            dropping        <= 1'b0;
            drop_count      <= '0;
            link_credit_out <= '0;
        end else begin
            assert (!overflow);
            if (link_rx_valid) have_lo <= (link_rx_hi == BEAT_LO);
            if (asm_vld) begin
                in_pkt <= !link_rx_last;
                if (!in_pkt) dropping <= foreign;
            end
            if (asm_vld && !in_pkt && foreign && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            link_credit_out <= 2'(pop) + 2'(drop_flit);
        end
    end

    always_ff @(posedge clk) begin
        if (link_rx_valid && link_rx_hi == BEAT_LO) lo_byte <= link_rx_data;
    end

    peripheral_dbg_soc_ring_router_ext_fifo #(
        .DEPTH(CREDITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (keep && !overflow),
        .push_flit({link_rx_last, asm_data}),
        .pop      (pop),
        .head     (dii_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_peripheral_dbg_soc_ring_router_ext_link.sv
// Directed and randomized bench for the ring-router external link endpoint,
// with a second instance wired back-to-back for the loopback scenario.
module tb_peripheral_dbg_soc_ring_router_ext_link;
    import peripheral_dbg_soc_dii_channel::*;

    localparam int NCRED = 4;
    localparam int NF    = 60;

    typedef struct packed {
        logic       hi;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic loop;
    always #5 clk = ~clk;

    dii_flit    a_in, a_out, b_in, b_out;
    logic       a_in_ready, b_in_ready, a_out_ready, b_out_ready;
    logic [7:0] a_tx_data, b_tx_data, a_drop, b_drop;
    logic       a_tx_valid, a_tx_hi, a_tx_last, b_tx_valid, b_tx_hi, b_tx_last;
    logic [1:0] a_credit_out, b_credit_out, a_credit_in, b_credit_in;
    logic [7:0] a_rx_data;
    logic       a_rx_valid, a_rx_hi, a_rx_last;

    logic [7:0] t_rx_data;
    logic       t_rx_valid, t_rx_hi, t_rx_last;
    logic [1:0] t_credit_in;

    assign a_rx_data   = loop ? b_tx_data    : t_rx_data;
    assign a_rx_valid  = loop ? b_tx_valid   : t_rx_valid;
    assign a_rx_hi     = loop ? b_tx_hi      : t_rx_hi;
    assign a_rx_last   = loop ? b_tx_last    : t_rx_last;
    assign a_credit_in = loop ? b_credit_out : t_credit_in;
    assign b_credit_in = loop ? a_credit_out : 2'd0;

    peripheral_dbg_soc_ring_router_ext_link dut_a (
        .clk(clk), .rst(rst), .dii_in(a_in), .dii_in_ready(a_in_ready),
        .dii_out(a_out), .dii_out_ready(a_out_ready),
        .link_tx_data(a_tx_data), .link_tx_valid(a_tx_valid), .link_tx_hi(a_tx_hi),
        .link_tx_last(a_tx_last), .link_credit_in(a_credit_in),
        .link_rx_data(a_rx_data), .link_rx_valid(a_rx_valid), .link_rx_hi(a_rx_hi),
        .link_rx_last(a_rx_last), .link_credit_out(a_credit_out), .drop_count(a_drop)
    );

    peripheral_dbg_soc_ring_router_ext_link dut_b (
        .clk(clk), .rst(rst), .dii_in(b_in), .dii_in_ready(b_in_ready),
        .dii_out(b_out), .dii_out_ready(b_out_ready),
        .link_tx_data(b_tx_data), .link_tx_valid(b_tx_valid), .link_tx_hi(b_tx_hi),
        .link_tx_last(b_tx_last), .link_credit_in(b_credit_in),
        .link_rx_data(a_tx_data), .link_rx_valid(a_tx_valid), .link_rx_hi(a_tx_hi),
        .link_rx_last(a_tx_last), .link_credit_out(b_credit_out), .drop_count(b_drop)
    );

    int    tests = 0;
    int    fails = 0;
    int    exp_credits;
    int    credit_sum;
    logic  acc;
    beat_t beatq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the directed phases: check TX beats and ready against the
    // model at the falling edge, then account the handshake and credits.
    task automatic step();
        logic  rdy_exp;
        beat_t b;
        @(negedge clk);
        rdy_exp = (exp_credits != 0) && (beatq.size() != 2);
        chk("in_ready", a_in_ready, rdy_exp);
        if (beatq.size() != 0) begin
            b = beatq.pop_front();
            chk("tx_valid", a_tx_valid, 1);
            chk("tx_beat", {a_tx_hi, a_tx_last, a_tx_data}, b);
        end else begin
            chk("tx_idle", a_tx_valid, 0);
        end
        credit_sum += int'(a_credit_out);
        acc = a_in.valid && rdy_exp;
        @(posedge clk);
        if (acc) begin
            beatq.push_back(beat_t'{1'b0, 1'b0, a_in.data[7:0]});
            beatq.push_back(beat_t'{1'b1, a_in.last, a_in.data[15:8]});
        end
        exp_credits += int'(t_credit_in);
        exp_credits -= int'(acc);
        #1;
    endtask

    task automatic rx_beat(input logic [7:0] d, input logic hi, input logic last);
        t_rx_data  = d;
        t_rx_hi    = hi;
        t_rx_last  = last;
        t_rx_valid = 1'b1;
        step();
        t_rx_valid = 1'b0;
    endtask

    task automatic rx_flit(input logic [15:0] d, input logic last);
        rx_beat(d[7:0], 1'b0, 1'b0);
        rx_beat(d[15:8], 1'b1, last);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] qab[$];
        logic [16:0] qba[$];
        logic [31:0] r;
        int          nacc, idx, sa, sb, ra, rb;
        logic        ha, hb;

        rst = 1'b1; loop = 1'b0;
        a_in = '0; b_in = '0; a_out_ready = 1'b1; b_out_ready = 1'b1;
        t_rx_data = '0; t_rx_valid = 1'b0; t_rx_hi = 1'b0; t_rx_last = 1'b0; t_credit_in = '0;
        exp_credits = NCRED; credit_sum = 0; acc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", a_tx_valid, 0);
        chk("rst_tx_hi", a_tx_hi, 0);
        chk("rst_tx_last", a_tx_last, 0);
        chk("rst_tx_data", a_tx_data, 0);
        chk("rst_out_valid", a_out.valid, 0);
        chk("rst_credit_out", a_credit_out, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_credits", dut_a.credits, NCRED);
        @(posedge clk); #1 rst = 1'b0;

        // Single flit
        a_in = '{1'b1, 1'b1, 16'hA5C3};
        step();
        a_in.valid = 1'b0;
        step();
        step();
        chk("single_credits", dut_a.credits, 3);
        step();
        t_credit_in = 2'd1;
        step();
        t_credit_in = 2'd0;
        chk("single_restore", dut_a.credits, 4);

        // Credit exhaustion: six flits offered, four credits available
        nacc = 0; idx = 0;
        a_in = '{1'b1, 1'b1, 16'h1000};
        for (int c = 0; c < 16; c++) begin
            step();
            if (acc) begin
                nacc++; idx++;
                if (idx < 6) a_in.data = 16'(16'h1000 + idx);
                else a_in.valid = 1'b0;
            end
        end
        chk("exhaust_accepted", nacc, 4);
        chk("exhaust_ready", a_in_ready, 0);
        t_credit_in = 2'd1;
        step();
        t_credit_in = 2'd0;
        chk("fifth_ready", a_in_ready, 1);
        step();
        a_in.valid = 1'b0;
        repeat (3) step();
        t_credit_in = 2'd2;
        step();
        step();
        t_credit_in = 2'd0;
        chk("exhaust_restore", dut_a.credits, 4);

        // Filter: subnet-1 packet dropped, credits returned per flit
        credit_sum = 0;
        rx_flit(16'h0401, 1'b0);
        chk("drop_f0_out", a_out.valid, 0);
        rx_flit(16'h0000, 1'b0);
        chk("drop_f1_out", a_out.valid, 0);
        rx_flit(16'h7777, 1'b1);
        chk("drop_f2_out", a_out.valid, 0);
        step();
        step();
        chk("drop_count_1", a_drop, 1);
        chk("drop_credits", credit_sum, 3);

        credit_sum = 0;
        a_out_ready = 1'b0;
        rx_flit(16'h0123, 1'b0);
        chk("pass_head0", {a_out.valid, a_out.last, a_out.data}, {1'b1, 1'b0, 16'h0123});
        rx_flit(16'hBEEF, 1'b1);
        chk("pass_hold", {a_out.valid, a_out.last, a_out.data}, {1'b1, 1'b0, 16'h0123});
        chk("pass_no_credit", credit_sum, 0);
        a_out_ready = 1'b1;
        step();
        chk("pass_head1", {a_out.valid, a_out.last, a_out.data}, {1'b1, 1'b1, 16'hBEEF});
        step();
        chk("pass_empty", a_out.valid, 0);
        step();
        chk("pass_credits", credit_sum, 2);
        chk("pass_drop_same", a_drop, 1);

        // Beat errors
        rx_beat(8'h77, 1'b1, 1'b1);
        chk("lone_hi", a_out.valid, 0);
        a_out_ready = 1'b0;
        rx_beat(8'h11, 1'b0, 1'b0);
        rx_beat(8'h22, 1'b0, 1'b0);
        rx_beat(8'h02, 1'b1, 1'b1);
        chk("double_lo", {a_out.valid, a_out.last, a_out.data}, {1'b1, 1'b1, 16'h0222});
        a_out_ready = 1'b1;
        step();
        chk("double_lo_pop", a_out.valid, 0);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            rx_flit({6'd5, r[9:0]}, 1'b1);
            if (i == 100) chk("drop_count_mid", a_drop, 102);
        end
        step();
        chk("drop_saturate", a_drop, 255);
        chk("drop_sat_out", a_out.valid, 0);

        // Reset between low and high beats
        a_in = '{1'b1, 1'b1, 16'h5A3C};
        rx_beat(8'h99, 1'b0, 1'b0);
        a_in.valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("mid_tx_valid", a_tx_valid, 0);
        chk("mid_tx_hi", a_tx_hi, 0);
        chk("mid_tx_last", a_tx_last, 0);
        chk("mid_tx_data", a_tx_data, 0);
        chk("mid_out_valid", a_out.valid, 0);
        chk("mid_credit_out", a_credit_out, 0);
        chk("mid_drop", a_drop, 0);
        chk("mid_in_ready", a_in_ready, 1);
        chk("mid_credits", dut_a.credits, NCRED);
        beatq.delete();
        exp_credits = NCRED;
        @(posedge clk); #1 rst = 1'b0;
        rx_beat(8'h44, 1'b1, 1'b1);
        chk("mid_lo_gone", a_out.valid, 0);
        a_in = '{1'b1, 1'b1, 16'hC0DE};
        step();
        a_in.valid = 1'b0;
        repeat (3) step();
        a_out_ready = 1'b0;
        rx_flit(16'h00AB, 1'b1);
        chk("mid_rx_flit", {a_out.valid, a_out.last, a_out.data}, {1'b1, 1'b1, 16'h00AB});
        a_out_ready = 1'b1;
        t_credit_in = 2'd1;
        step();
        t_credit_in = 2'd0;
        chk("mid_credits_back", dut_a.credits, NCRED);

        // Loopback of both instances with random packets and stalls
        rst = 1'b1; loop = 1'b1;
        a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sa = 0; sb = 0; ra = 0; rb = 0;
        for (int cyc = 0; cyc < 4000 && (ra < NF || rb < NF); cyc++) begin
            @(negedge clk);
            if (b_out.valid && b_out_ready) begin
                chk("ab_flit", {b_out.last, b_out.data}, (qab.size() != 0) ? {15'd0, qab.pop_front()} : 32'hFFFF_FFFF);
                rb++;
            end
            if (a_out.valid && a_out_ready) begin
                chk("ba_flit", {a_out.last, a_out.data}, (qba.size() != 0) ? {15'd0, qba.pop_front()} : 32'hFFFF_FFFF);
                ra++;
            end
            chk("a_cred_max", dut_a.credits <= NCRED, 1);
            chk("b_cred_max", dut_b.credits <= NCRED, 1);
            ha = a_in.valid && a_in_ready;
            hb = b_in.valid && b_in_ready;
            @(posedge clk); #1;
            if (ha) begin qab.push_back({a_in.last, a_in.data}); sa++; end
            if (hb) begin qba.push_back({b_in.last, b_in.data}); sb++; end
            if (!a_in.valid || ha) begin
                r = $urandom;
                a_in.valid = (sa < NF) && (r[17:16] != 2'd0);
                a_in.last  = (sa % 3) == 2;
                a_in.data  = ((sa % 3) == 0) ? {6'd0, r[9:0]} : r[15:0];
            end
            if (!b_in.valid || hb) begin
                r = $urandom;
                b_in.valid = (sb < NF) && (r[17:16] != 2'd0);
                b_in.last  = (sb % 3) == 2;
                b_in.data  = ((sb % 3) == 0) ? {6'd0, r[9:0]} : r[15:0];
            end
            a_out_ready = $urandom_range(0, 3) != 0;
            b_out_ready = $urandom_range(0, 3) != 0;
        end
        chk("ab_count", rb, NF);
        chk("ba_count", ra, NF);
        chk("ab_left", qab.size(), 0);
        chk("ba_left", qba.size(), 0);
        chk("loop_no_drop", {a_drop, b_drop}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
